// File: rtl/instr_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and streams
// them into instruction memory through a back-pressured write port.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          DEPTH     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inValid,
    output logic              inReady,
    input  logic [6:0]        op,
    input  logic [2:0]        func3,
    input  logic              func7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              imWe,
    output logic [ADDR_W-1:0] imAddr,
    output logic [31:0]       imData,
    input  logic              imReady,
    output logic [ADDR_W-1:0] count,
    output logic              done,
    output logic              illegal,
    output logic              full
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_in_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic [ADDR_W-1:0]   r_count;
    logic                r_done;
    logic                r_illegal;
    logic                r_full;

    logic [31:0]         w_enc;
    logic                w_legal;
    logic signed [31:0]  w_imm;
    logic                w_i_ok;
    logic                w_b_ok;
    logic                w_j_ok;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                w_at_depth;

    assign w_imm  = $signed(imm);
    assign w_i_ok = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
    assign w_b_ok = (w_imm >= -32'sd4096) && (w_imm <= 32'sd4094)
                    && !imm[0];
    assign w_j_ok = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048574)
                    && !imm[0];

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b0;
        case (op)
            7'b0110011: begin
                w_enc   = {1'b0, func7, 5'b0, rs2, rs1, func3, rd, op};
                w_legal = 1'b1;
            end
            7'b0010011, 7'b0000011: begin
                w_enc   = {imm[11:0], rs1, func3, rd, op};
                w_legal = w_i_ok;
            end
            7'b0100011: begin
                w_enc   = {imm[11:5], rs2, rs1, func3, imm[4:0], op};
                w_legal = w_i_ok;
            end
            7'b1100011: begin
                w_enc   = {imm[12], imm[10:5], rs2, rs1, func3,
                           imm[4:1], imm[11], op};
                w_legal = w_b_ok;
            end
            7'b1101111: begin
                w_enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                w_legal = w_j_ok;
            end
            default: begin
                w_enc   = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_cnt_nxt  = r_count + ADDR_W'(1);
    assign w_at_depth = (w_cnt_nxt == ADDR_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_data     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= ACCEPT;
                        r_in_ready <= 1'b1;
                        r_addr     <= ADDR_W'(BASE_ADDR);
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_illegal  <= 1'b0;
                        r_full     <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (inValid) begin
                        if (w_legal) begin
                            r_data     <= w_enc;
                            r_last     <= last;
                            r_in_ready <= 1'b0;
                            r_we       <= 1'b1;
                            r_state    <= WRITE;
                        end else begin
                            r_illegal <= 1'b1;
                            if (last) begin
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= DONE;
                            end
                        end
                    end
                end
                WRITE: begin
                    // Address, data and strobe stay frozen until IMEM accepts.
                    if (imReady) begin
                        r_we    <= 1'b0;
                        r_addr  <= r_addr + ADDR_W'(4);
                        r_count <= w_cnt_nxt;
                        if (r_last || w_at_depth) begin
                            r_full  <= r_full | w_at_depth;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ACCEPT;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inReady = r_in_ready;
    assign imWe    = r_we;
    assign imAddr  = r_addr;
    assign imData  = r_data;
    assign count   = r_count;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign full    = r_full;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Reverse of the control-unit decode path: takes instruction fields (op, func3, func7, rd, rs1, rs2, imm) and packs them into 32-bit RV32I words.
- Streams the packed words into instruction memory through a write port.
- Used by the testbench and boot path to load programs into the single-cycle core's IMEM.
- Sequential behaviour: valid/ready input handshake, write-back-pressure handshake, address/count tracking, sticky error flags.

Parameters:
ADDR_W, 8, width of IMEM byte address.
BASE_ADDR, 0, byte address of the first written word.
DEPTH, 64, maximum number of words per load session.

Ports:
clk  in  1  clock; rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  pulse; opens a load session.
inValid  in  1  field bundle valid.
inReady  out  1  field bundle accepted when inValid & inReady.
op  in  7  opcode.
func3  in  3  func3.
func7  in  1  instruction bit 30 (R-type only).
rd  in  5  destination register.
rs1  in  5  source register 1.
rs2  in  5  source register 2.
imm  in  32  signed immediate, byte offset for B/J.
last  in  1  marks final bundle of the session.
imWe  out  1  IMEM write request.
imAddr  out  ADDR_W  IMEM byte address.
imData  out  32  encoded instruction.
imReady  in  1  IMEM accepts write when imWe & imReady.
count  out  ADDR_W  words written this session.
done  out  1  session finished.
illegal  out  1  sticky: at least one bundle rejected.
full  out  1  sticky: DEPTH reached.

Behaviour:
- Reset (rst_n=0, async): state IDLE. inReady=0, imWe=0, imAddr=BASE_ADDR, imData=0, count=0, done=0, illegal=0, full=0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE/DONE + start:
  - go to ACCEPT.
  - imAddr=BASE_ADDR; count, done, illegal, full cleared.
  - start is ignored in ACCEPT and WRITE.
- ACCEPT: inReady=1.
  - On handshake: encode and register into imData; capture last.
  - Legal bundle → WRITE; imWe=1 from the next cycle.
  - Illegal bundle → illegal=1, no write. Next state is DONE if last, else stays ACCEPT.
- WRITE: inReady=0; imWe, imAddr and imData held stable until imReady.
  - On imWe & imReady: imAddr+=4 (wraps mod 2^ADDR_W); count+=1.
  - If captured last, or the new count==DEPTH: go to DONE; set full when count==DEPTH.
  - Otherwise → ACCEPT.
- DONE: done=1, inReady=0, imWe=0. Outputs hold until start or reset.
- Latency and throughput: handshake at edge N → imWe=1 in cycle N+1. With imReady tied high, peak rate is 1 word per 2 cycles.
- Encoding by op:
  - 0110011 R: {1'b0, func7, 5'b0, rs2, rs1, func3, rd, op}.
  - 0010011 / 0000011 I: {imm[11:0], rs1, func3, rd, op}.
  - 0100011 S: {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - 1100011 B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
  - 1101111 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Illegal conditions:
  - any other opcode.
  - I/S with imm outside [-2048, 2047].
  - B with imm outside [-4096, 4094] or imm[0]=1.
  - J with imm outside ±2^20 or imm[0]=1.
- Ignored fields: unused fields per format are ignored; func7 is ignored except for R.
- Reset asserted mid-WRITE: write aborted immediately (imWe=0 asynchronously); the IMEM word is not counted.

Test Plan:
- start; add x3,x1,x2 (op=0110011, f3=0, f7=0, last=1), imReady=1 → imData=0x002081B3 at imAddr=0; count=1; done=1.
- sub x3,x1,x2 (f7=1) then sw x5,8(x2) (last) → writes 0x402081B3 @0, 0x00512423 @4; count=2.
- beq x0,x0,imm=-4 → 0xFE000EE3. Same bundle with imm=-3 → illegal=1, imWe never asserted, count=0.
- Back-pressure: imReady low 3 cycles → imWe, imAddr, imData stable all 3 cycles, inReady=0. Single write on release; count increments once.
- DEPTH=2, three legal bundles with last only on the third → two writes, full=1, done=1; third bundle not accepted (inReady=0).
- Reset pulse while imWe=1 and imReady=0 → all outputs at reset values immediately. A following start plus one bundle writes at BASE_ADDR with count=1.
